answer_arbiter: RTL and testbench

ANSWER_ARBITER -- requirements
Module: answer_arbiter

---
 rtl/answer_arbiter_pkg.sv | 14 +
 rtl/answer_arbiter_if.sv | 30 +++
 rtl/answer_arbiter_key_sync.sv | 33 +++
 rtl/answer_arbiter.sv | 109 ++++++++++
 tb/tb_answer_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/answer_arbiter_pkg.sv
// Shared constants for the answer arbiter: FSM state encodings used by the
// arbiter itself, display logic and the testbench.
package answer_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_EXPIRED = 2'd3
  } arb_state_e;

endpackage

// File: rtl/answer_arbiter_if.sv
// Host/contestant/countdown signal bundle for the answer arbiter.
// The host side (master) drives buttons and host controls; the arbiter is the slave.
interface answer_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);

  logic [N-1:0]   key;
  logic           host_start;
  logic           host_clear;
  logic           host_pause;
  logic           timeout;
  logic           run_pause;
  logic           cd_rst_n;
  logic [IDW-1:0] winner;
  logic           winner_valid;
  logic [N-1:0]   foul;
  logic [1:0]     state_o;

  modport master (
    output key, host_start, host_clear, host_pause, timeout,
    input  run_pause, cd_rst_n, winner, winner_valid, foul, state_o
  );

  modport slave (
    input  key, host_start, host_clear, host_pause, timeout,
    output run_pause, cd_rst_n, winner, winner_valid, foul, state_o
  );

endinterface

// File: rtl/answer_arbiter_key_sync.sv
// One-bit 2-flop synchroniser with rising-edge detector; press_o is a
// single-cycle pulse per genuine button press.
module key_sync (
  input  logic clkout,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic [2:0] fill_q;

  // fill_q marks when prev_q holds a real key sample, so a key held across
  // reset release is not mistaken for a fresh press.
  always_ff @(posedge clkout) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= key_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign press_o = s2_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/answer_arbiter.sv
// Quiz answer arbiter: synchronises contestant buttons, locks the first
// valid press (lowest index on ties) and drives the countdown stage.
module answer_arbiter
  import answer_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic              clkout,
  input  logic              rst_n,
  answer_arbiter_if.slave   bus
);

  logic [N-1:0]   press;
  logic [N-1:0]   validPress;
  logic [IDW-1:0] firstIdx;
  logic           anyValid;
  logic           startRise;
  logic           start_q;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] winner_q, winner_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   foul_q, foul_d;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_sync
      key_sync u_sync (
        .clkout  (clkout),
        .rst_n   (rst_n),
        .key_i   (bus.key[g]),
        .press_o (press[g])
      );
    end
  endgenerate

  assign startRise = bus.host_start & ~start_q;

  // Descending scan so the lowest-index valid press is the one left standing.
  always_comb begin
    validPress = press & ~foul_q;
    firstIdx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (validPress[i]) firstIdx = IDW'(i);
    end
    anyValid = |validPress;
  end

  always_ff @(posedge clkout) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      valid_q  <= 1'b0;
      foul_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      valid_q  <= valid_d;
      foul_q   <= foul_d;
      start_q  <= bus.host_start;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    valid_d  = valid_q;
    foul_d   = foul_q;
    if (bus.host_clear) begin
      state_d  = ST_IDLE;
      winner_d = '0;
      valid_d  = 1'b0;
      foul_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          foul_d = foul_q | press;
          if (startRise) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (anyValid) begin
            state_d  = ST_LOCKED;
            winner_d = firstIdx;
            valid_d  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (bus.timeout) state_d = ST_EXPIRED;
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.run_pause    = (state_q == ST_LOCKED) && !bus.host_pause;
  assign bus.cd_rst_n     = (state_q == ST_LOCKED) || (state_q == ST_EXPIRED);
  assign bus.winner       = winner_q;
  assign bus.winner_valid = valid_q;
  assign bus.foul         = foul_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_answer_arbiter.sv
// Self-checking bench for answer_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a key-history reference model.
module tb_answer_arbiter;
  import answer_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clkout;
  logic rst_n;

  answer_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  answer_arbiter #(.N(N), .IDW(IDW)) dut (
    .clkout (clkout),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] keyHist[$];
  int           cyc;
  int           lastRst = 0;
  bit           modelReady = 0;
  int           mState;
  int           mWinner;
  bit           mValid;
  logic [N-1:0] mFoul;
  bit           prevStart;
  logic [N-1:0] mPress;
  logic [N-1:0] mCand;
  bit           mStartRise;
  bit           found;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkout);
    #2;
  endtask

  task automatic startPulse();
    bus.host_start = 1'b1;
    tick(1);
    bus.host_start = 1'b0;
  endtask

  task automatic clearPulse();
    bus.host_clear = 1'b1;
    tick(1);
    bus.host_clear = 1'b0;
  endtask

  // A press takes effect at edge E when the key was sampled high two edges
  // earlier and low three edges earlier, with both samples taken after reset.
  always @(posedge clkout) begin
    keyHist.push_back(bus.key);
    cyc = keyHist.size() - 1;
    if (!rst_n) begin
      mState     = 0;
      mWinner    = 0;
      mValid     = 0;
      mFoul      = '0;
      prevStart  = 0;
      lastRst    = cyc;
      modelReady = 1;
    end else begin
      mPress     = (cyc >= lastRst + 4) ? (keyHist[cyc-2] & ~keyHist[cyc-3]) : '0;
      mStartRise = bus.host_start && !prevStart;
      prevStart  = bus.host_start;
      if (bus.host_clear) begin
        mState  = 0;
        mWinner = 0;
        mValid  = 0;
        mFoul   = '0;
      end else if (mState == 0) begin
        mFoul = mFoul | mPress;
        if (mStartRise) mState = 1;
      end else if (mState == 1) begin
        mCand = mPress & ~mFoul;
        found = 0;
        for (int i = 0; i < N; i++) begin
          if (!found && mCand[i]) begin
            found   = 1;
            mWinner = i;
          end
        end
        if (found) begin
          mState = 2;
          mValid = 1;
        end
      end else if (mState == 2) begin
        if (bus.timeout) mState = 3;
      end
    end
  end

  always @(negedge clkout) begin
    if (modelReady) begin
      checkOutput("state",        32'(bus.state_o),      32'(mState));
      checkOutput("winner",       32'(bus.winner),       32'(mWinner));
      checkOutput("winner_valid", 32'(bus.winner_valid), 32'(mValid));
      checkOutput("foul",         32'(bus.foul),         32'(mFoul));
      checkOutput("run_pause",    32'(bus.run_pause),    32'((mState == 2) && !bus.host_pause));
      checkOutput("cd_rst_n",     32'(bus.cd_rst_n),     32'(mState >= 2));
    end
  end

  task automatic applyStimulus();
    logic [N-1:0] mask;
    for (int c = 0; c < 3000; c++) begin
      mask           = N'($urandom & $urandom);
      bus.key        = bus.key ^ mask;
      bus.host_start = ($urandom % 4) == 0;
      bus.host_clear = ($urandom % 25) == 0;
      bus.host_pause = ($urandom % 3) == 0;
      bus.timeout    = ($urandom % 8) == 0;
      rst_n          = !(($urandom % 300) == 0);
      tick(1);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.key        = '0;
    bus.host_start = 1'b0;
    bus.host_clear = 1'b0;
    bus.host_pause = 1'b0;
    bus.timeout    = 1'b0;
    tick(3);
    checkOutput("rst state",     32'(bus.state_o),      32'(ST_IDLE));
    checkOutput("rst winner",    32'(bus.winner),       32'd0);
    checkOutput("rst valid",     32'(bus.winner_valid), 32'd0);
    checkOutput("rst foul",      32'(bus.foul),         32'd0);
    checkOutput("rst run_pause", 32'(bus.run_pause),    32'd0);
    checkOutput("rst cd_rst_n",  32'(bus.cd_rst_n),     32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single press locks channel 2
    startPulse();
    checkOutput("d1 armed", 32'(bus.state_o), 32'd1);
    bus.key = 4'b0100;
    tick(3);
    checkOutput("d1 state",  32'(bus.state_o),      32'd2);
    checkOutput("d1 winner", 32'(bus.winner),       32'd2);
    checkOutput("d1 valid",  32'(bus.winner_valid), 32'd1);
    checkOutput("d1 run",    32'(bus.run_pause),    32'd1);
    checkOutput("d1 cd",     32'(bus.cd_rst_n),     32'd1);
    bus.key = '0;
    clearPulse();
    checkOutput("d1 cleared", 32'(bus.state_o), 32'd0);

    // Tie goes to lowest index; later presses ignored
    startPulse();
    bus.key = 4'b1010;
    tick(3);
    checkOutput("d2 winner", 32'(bus.winner), 32'd1);
    bus.key = '0;
    tick(2);
    bus.key = 4'b0001;
    tick(4);
    checkOutput("d2 winner held", 32'(bus.winner), 32'd1);
    bus.key = '0;
    clearPulse();

    // Early press fouls the channel, which then cannot win
    tick(2);
    bus.key = 4'b1000;
    tick(3);
    checkOutput("d3 foul", 32'(bus.foul), 32'b1000);
    bus.key = '0;
    tick(2);
    startPulse();
    bus.key = 4'b1000;
    tick(3);
    checkOutput("d3 still armed", 32'(bus.state_o), 32'd1);
    bus.key = '0;
    tick(2);
    bus.key = 4'b0001;
    tick(3);
    checkOutput("d3 state",  32'(bus.state_o), 32'd2);
    checkOutput("d3 winner", 32'(bus.winner),  32'd0);
    bus.key = '0;
    clearPulse();

    // Pause then timeout
    startPulse();
    bus.key = 4'b0010;
    tick(3);
    bus.key = '0;
    bus.host_pause = 1'b1;
    tick(1);
    checkOutput("d4 paused run", 32'(bus.run_pause), 32'd0);
    checkOutput("d4 paused st",  32'(bus.state_o),   32'd2);
    bus.timeout = 1'b1;
    tick(1);
    bus.timeout    = 1'b0;
    bus.host_pause = 1'b0;
    #1;
    checkOutput("d4 expired", 32'(bus.state_o),   32'd3);
    checkOutput("d4 run",     32'(bus.run_pause), 32'd0);
    checkOutput("d4 winner",  32'(bus.winner),    32'd1);
    checkOutput("d4 valid",   32'(bus.winner_valid), 32'd1);
    clearPulse();

    // Clear beats a simultaneous valid press
    bus.key = 4'b1000;
    tick(3);
    bus.key = '0;
    tick(2);
    startPulse();
    bus.key = 4'b0100;
    tick(2);
    bus.host_clear = 1'b1;
    tick(1);
    bus.host_clear = 1'b0;
    checkOutput("d5 state", 32'(bus.state_o),      32'd0);
    checkOutput("d5 valid", 32'(bus.winner_valid), 32'd0);
    checkOutput("d5 foul",  32'(bus.foul),         32'd0);
    bus.key = '0;
    tick(2);

    // Reset mid-round with a key held across release
    startPulse();
    bus.key = 4'b0010;
    tick(3);
    checkOutput("d6 locked", 32'(bus.state_o), 32'd2);
    rst_n = 1'b0;
    tick(1);
    checkOutput("d6 rst state", 32'(bus.state_o),      32'd0);
    checkOutput("d6 rst valid", 32'(bus.winner_valid), 32'd0);
    checkOutput("d6 rst cd",    32'(bus.cd_rst_n),     32'd0);
    rst_n = 1'b1;
    startPulse();
    tick(4);
    checkOutput("d6 no press", 32'(bus.state_o), 32'd1);
    bus.key = '0;
    tick(3);
    bus.key = 4'b0010;
    tick(3);
    checkOutput("d6 repress st", 32'(bus.state_o), 32'd2);
    checkOutput("d6 repress w",  32'(bus.winner),  32'd1);
    bus.key = '0;
    clearPulse();

    applyStimulus();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
